// File: rtl/classify_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : classify_seq_ctrl
// Brief   : Per-frame classification sequencer: request/ack to the decision
//           tree, majority vote over VOTE_N frames, frame-aligned commit.
// Revision: 1.0
// ============================================================================
module classify_seq_ctrl #(
    parameter int FEAT_W  = 20,
    parameter int VOTE_N  = 4,
    parameter int TMO_CYC = 1023
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              lable_start,
    input  logic [FEAT_W-1:0] feature0,
    input  logic [FEAT_W-1:0] feature1,
    input  logic              frame_end,
    output logic              tree_req,
    output logic [FEAT_W-1:0] tree_f0,
    output logic [FEAT_W-1:0] tree_f1,
    input  logic              tree_ack,
    input  logic [1:0]        tree_class,
    output logic [3:0]        tree_out,
    output logic              result_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        drop_cnt
);

    localparam int CW = $clog2(VOTE_N + 1);
    localparam int TW = 16;
    localparam logic [TW-1:0] c_tmo_last  = TW'(TMO_CYC - 1);
    localparam logic [CW-1:0] c_vote_last = CW'(VOTE_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_VOTE   = 2'd2,
        S_DECIDE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_timeout;
    logic [TW-1:0]   r_wait;
    logic [1:0]      r_cls;
    logic [CW-1:0]   r_votes [4];
    logic [CW-1:0]   r_vote_idx;
    logic [3:0]      r_pending;
    logic            r_pend_valid;
    logic [1:0]      w_win;
    logic [CW-1:0]   w_best;
    logic [3:0]      w_onehot;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lable_start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the timeout cycle still counts as a valid answer.
                if (tree_ack) begin
                    w_next = S_VOTE;
                end else if (r_wait == c_tmo_last) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_VOTE:   w_next = (r_vote_idx == c_vote_last) ? S_DECIDE : S_IDLE;
            S_DECIDE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (!enable) begin
            w_next    = S_IDLE;
            w_timeout = 1'b0;
        end
    end

    // Strict '>' keeps the lowest class index on a tie.
    always_comb begin
        w_win  = 2'd0;
        w_best = r_votes[0];
        for (int i = 1; i < 4; i++) begin
            if (r_votes[i] > w_best) begin
                w_best = r_votes[i];
                w_win  = 2'(i);
            end
        end
        w_onehot = 4'b0001 << w_win;
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            tree_req     <= 1'b0;
            tree_f0      <= '0;
            tree_f1      <= '0;
            tree_out     <= 4'b1000;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            drop_cnt     <= 8'd0;
            r_wait       <= '0;
            r_cls        <= 2'd0;
            r_vote_idx   <= '0;
            r_pending    <= 4'b1000;
            r_pend_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_votes[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            if (!enable) begin
                tree_req     <= 1'b0;
                r_vote_idx   <= '0;
                r_pend_valid <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    r_votes[i] <= '0;
                end
            end else begin
                // Commit uses the pending flag as registered before this edge;
                // a DECIDE in the same cycle re-arms it below.
                if (frame_end && r_pend_valid) begin
                    tree_out     <= r_pending;
                    result_valid <= 1'b1;
                    r_pend_valid <= 1'b0;
                end
                if (lable_start && busy && (drop_cnt != 8'hFF)) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (lable_start) begin
                            tree_f0  <= feature0;
                            tree_f1  <= feature1;
                            tree_req <= 1'b1;
                            r_wait   <= '0;
                        end
                    end
                    S_REQ: begin
                        if (tree_ack) begin
                            r_cls    <= tree_class;
                            tree_req <= 1'b0;
                        end else if (w_timeout) begin
                            tree_req    <= 1'b0;
                            timeout_err <= 1'b1;
                        end else begin
                            r_wait <= r_wait + TW'(1);
                        end
                    end
                    S_VOTE: begin
                        r_votes[r_cls] <= r_votes[r_cls] + CW'(1);
                        r_vote_idx     <= r_vote_idx + CW'(1);
                    end
                    S_DECIDE: begin
                        r_pending    <= w_onehot;
                        r_pend_valid <= 1'b1;
                        r_vote_idx   <= '0;
                        for (int i = 0; i < 4; i++) begin
                            r_votes[i] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/classify_seq_ctrl.md
Name: classify_seq_ctrl

Overview:
Sequences per-frame classification of the pretreatment feature counters.
- On each end-of-ROI strobe, latches feature0/feature1 and issues one request to the decision-tree evaluator over a req/ack handshake.
- Majority-votes the returned classes over VOTE_N frames.
- Commits the winning one-hot class to the overlay at a frame boundary, so the glyph never changes mid-frame.

Parameters:
FEAT_W, 20, width of each feature count
VOTE_N, 4, frames per decision (1..15)
TMO_CYC, 1023, max cycles to wait for tree_ack (1..65535)

Ports:
cam_pclk  in  1  pixel clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; low aborts and holds the controller idle
lable_start  in  1  one-cycle strobe: feature counters are final for this frame
feature0  in  FEAT_W  dark-pixel count in ROI
feature1  in  FEAT_W  light-pixel count in ROI
frame_end  in  1  one-cycle strobe at the last pixel of the frame
tree_req  out  1  request to evaluator
tree_f0  out  FEAT_W  latched feature0, stable while tree_req=1
tree_f1  out  FEAT_W  latched feature1, stable while tree_req=1
tree_ack  in  1  evaluator done; tree_class valid in the same cycle
tree_class  in  2  class index 0..3
tree_out  out  4  committed one-hot class to overlay
result_valid  out  1  one-cycle pulse when tree_out updates
busy  out  1  high when the FSM is not in IDLE
timeout_err  out  1  sticky; cleared only by reset
drop_cnt  out  8  saturating count of lable_start strobes ignored while busy

Behaviour:
- Reset values: tree_req=0, tree_f0=tree_f1=0, tree_out=4'b1000, result_valid=0, busy=0, timeout_err=0, drop_cnt=0.
- Reset also clears the vote counters, vote_idx and pending_valid.
- FSM states: IDLE, REQ, VOTE, DECIDE.
- IDLE: on lable_start with enable=1:
  - latch feature0/feature1 into tree_f0/tree_f1;
  - go to REQ; tree_req=1 from the next cycle (latency 1).
- REQ:
  - tree_req held high; tree_f0/f1 frozen; wait counter increments each cycle.
  - tree_ack=1: capture tree_class, deassert tree_req next cycle, go to VOTE.
  - Wait counter reaching TMO_CYC with no ack: set timeout_err, drop tree_req, discard the sample (no vote), return to IDLE.
  - tree_ack asserted in the same cycle as the timeout: ack wins.
- VOTE (1 cycle):
  - increment vote counter [captured class]; vote_idx++.
  - If vote_idx reaches VOTE_N, go to DECIDE; else go to IDLE.
- DECIDE (1 cycle):
  - winner = class with the highest count; ties resolve to the lowest index.
  - pending <= onehot(winner); pending_valid=1; clear all vote counters and vote_idx; go to IDLE.
  - A new decision while pending_valid=1 overwrites pending.
- Commit:
  - On frame_end with pending_valid=1 (registered before this cycle): tree_out <= pending, result_valid=1 for exactly one cycle, pending_valid=0.
  - frame_end in the same cycle that DECIDE writes pending: no commit; the decision commits at the next frame_end.
  - tree_out otherwise holds.
- lable_start while busy=1: ignored; drop_cnt++, saturating at 255.
- enable=0 (any state, next cycle):
  - FSM to IDLE; tree_req=0; vote counters, vote_idx and pending_valid cleared.
  - tree_out, timeout_err and drop_cnt hold.
  - lable_start ignored without counting.
- Vote counter width: ceil(log2(VOTE_N+1)); counters cannot overflow because they are cleared every VOTE_N votes.
- tree_ack outside REQ is ignored.
- All state is on cam_pclk; no combinational path from inputs to outputs.

Test Plan:
1. Reset, VOTE_N=4; evaluator acks 3 cycles after req with classes 1,1,2,1 across 4 frames.
   -> tree_req rises 1 cycle after each lable_start, and tree_f0/tree_f1 equal the values at lable_start.
   -> tree_out=4'b0010 with result_valid pulse at the first frame_end after the 4th vote.
2. Votes 0,0,3,3 -> tie -> tree_out=4'b0001. Then votes 2,2,2,2 -> tree_out=4'b0100.
3. Evaluator never acks, TMO_CYC=16.
   -> tree_req drops 16 cycles after rising; timeout_err=1; no vote counted.
   -> the next frame's ack still works, and the decision needs 4 successful votes.
4. lable_start pulsed 3 times while in REQ -> drop_cnt=3; 300 such pulses -> drop_cnt=255.
5. enable dropped after 2 of 4 votes, then re-raised.
   -> tree_req=0 next cycle; tree_out unchanged.
   -> 4 fresh votes are required before the next commit.
6. frame_end coincident with DECIDE -> no result_valid that cycle; commit at the following frame_end. Reset asserted mid-REQ -> all outputs return to reset values immediately.
